memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage.sv | 155 +++++++++++++++
 tb/tb_memory_access_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: drives a req/ready data-memory port for loads and stores,
// formats store lanes, extracts load data and loads the MEM/WB register.
module memory_access_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_wb_en_ex_mem_o,
    input  logic [4:0]        rd_ex_mem_o,
    input  logic [31:0]       pc_ex_mem_o,
    input  logic [1:0]        wb_sel_ex_mem_o,
    input  logic [31:0]       imm_ex_mem_o,
    input  logic [31:0]       alu_out_ex_mem_o,
    input  logic [31:0]       rs2_ex_mem_o,
    input  logic [2:0]        funct3_ex_mem_o,
    input  logic              is_load_instr_ex_mem_o,
    input  logic              is_store_instr_ex_mem_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_wstrb_o,
    input  logic              dmem_ready_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              busywait_o,
    output logic              reg_wb_en_mem_wb_o,
    output logic [4:0]        rd_mem_wb_o,
    output logic [31:0]       pc_mem_wb_o,
    output logic [1:0]        wb_sel_mem_wb_o,
    output logic [31:0]       imm_mem_wb_o,
    output logic [31:0]       alu_out_mem_wb_o,
    output logic [31:0]       rd_data_mem_wb_o,
    output logic              is_memory_instruction_mem_wb_o,
    output logic              mem_fault_mem_wb_o
);

    typedef enum logic {StIdle, StWait} state_t;

    state_t            state;
    logic              held_we;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_wdata;
    logic [3:0]        held_wstrb;

    logic              is_ld, is_st, any_mem, unsupported, misaligned, fault, go, in_wait;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        st_strb;
    logic [31:0]       st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;

    always_comb begin
        is_ld       = is_load_instr_ex_mem_o;
        is_st       = is_store_instr_ex_mem_o;
        lane        = alu_out_ex_mem_o[1:0];
        any_mem     = is_ld | is_st;
        unsupported = (is_ld & is_st)
                    | (is_ld & ((funct3_ex_mem_o == 3'b011) | (funct3_ex_mem_o[2:1] == 2'b11)))
                    | (is_st & (funct3_ex_mem_o >= 3'b011));
        misaligned  = ((funct3_ex_mem_o[1:0] == 2'b01) & lane[0])
                    | ((funct3_ex_mem_o[1:0] == 2'b10) & (lane != 2'b00));
        fault       = any_mem & (unsupported | misaligned);
        go          = (is_ld ^ is_st) & ~fault;
        word_addr   = ADDR_W'(alu_out_ex_mem_o);
        word_addr[1:0] = 2'b00;
    end

    always_comb begin
        st_strb = 4'b1111;
        st_data = rs2_ex_mem_o;
        case (funct3_ex_mem_o[1:0])
            2'b00: begin
                st_strb = 4'b0001 << lane;
                st_data = {4{rs2_ex_mem_o[7:0]}};
            end
            2'b01: begin
                st_strb = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rs2_ex_mem_o[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = 8'(dmem_rdata_i >> {lane, 3'b000});
        ld_half = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_ex_mem_o)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'b0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = dmem_rdata_i;
        endcase
    end

    // Reset gates the request combinationally so it drops without waiting for an edge.
    always_comb begin
        in_wait      = (state == StWait);
        dmem_req_o   = ~rst_i & (in_wait | go);
        dmem_we_o    = dmem_req_o & (in_wait ? held_we : is_st);
        dmem_addr_o  = in_wait ? held_addr : word_addr;
        dmem_wdata_o = in_wait ? held_wdata : st_data;
        dmem_wstrb_o = dmem_we_o ? (in_wait ? held_wstrb : st_strb) : 4'b0000;
        busywait_o   = ~rst_i & (in_wait ? ~dmem_ready_i : go);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                          <= StIdle;
            held_we                        <= 1'b0;
            held_addr                      <= '0;
            held_wdata                     <= '0;
            held_wstrb                     <= '0;
            reg_wb_en_mem_wb_o             <= 1'b0;
            rd_mem_wb_o                    <= '0;
            pc_mem_wb_o                    <= '0;
            wb_sel_mem_wb_o                <= '0;
            imm_mem_wb_o                   <= '0;
            alu_out_mem_wb_o               <= '0;
            rd_data_mem_wb_o               <= '0;
            is_memory_instruction_mem_wb_o <= 1'b0;
            mem_fault_mem_wb_o             <= 1'b0;
        end else begin
            case (state)
                StIdle: if (go) begin
                    state      <= StWait;
                    held_we    <= is_st;
                    held_addr  <= word_addr;
                    held_wdata <= st_data;
                    held_wstrb <= st_strb;
                end
                StWait: if (dmem_ready_i) state <= StIdle;
                default: state <= StIdle;
            endcase
            if (busywait_o) begin
                reg_wb_en_mem_wb_o             <= 1'b0;
                is_memory_instruction_mem_wb_o <= 1'b0;
                mem_fault_mem_wb_o             <= 1'b0;
            end else begin
                reg_wb_en_mem_wb_o             <= reg_wb_en_ex_mem_o & ~is_st & ~fault;
                rd_mem_wb_o                    <= rd_ex_mem_o;
                pc_mem_wb_o                    <= pc_ex_mem_o;
                wb_sel_mem_wb_o                <= wb_sel_ex_mem_o;
                imm_mem_wb_o                   <= imm_ex_mem_o;
                alu_out_mem_wb_o               <= alu_out_ex_mem_o;
                rd_data_mem_wb_o               <= (is_ld & ~fault) ? ld_val : 32'b0;
                is_memory_instruction_mem_wb_o <= is_ld & ~fault;
                mem_fault_mem_wb_o             <= fault;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: a driver issues directed vectors and pushes expected
// MEM/WB contents; a monitor pops and compares on every edge where the stage advances.
module tb_memory_access_stage;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  wb_sel;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic [3:0]  waits;
        logic        stray;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [3:0]  x_wstrb;
        logic [31:0] x_wdata;
        logic        x_wb_en;
        logic [31:0] x_rd_data;
        logic        x_is_mem;
        logic        x_fault;
    } vec_t;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  wb_sel;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] rd_data;
        logic        is_mem;
        logic        fault;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wb_en_ex_mem, is_load, is_store, dmem_ready;
    logic [4:0]  rd_ex_mem;
    logic [31:0] pc_ex_mem, imm_ex_mem, alu_ex_mem, rs2_ex_mem, dmem_rdata;
    logic [1:0]  wb_sel_ex_mem;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, busywait;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        reg_wb_en_mem_wb, is_mem_mem_wb, fault_mem_wb;
    logic [4:0]  rd_mem_wb;
    logic [31:0] pc_mem_wb, imm_mem_wb, alu_mem_wb, rd_data_mem_wb;
    logic [1:0]  wb_sel_mem_wb;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    bit   adv = 1'b0;
    bit   bub = 1'b0;
    wb_t  exp_q[$];
    vec_t vecs[15];

    always #5 clk = ~clk;

    memory_access_stage #(.ADDR_W(32)) dut (
        .clk_i                          (clk),
        .rst_i                          (rst),
        .reg_wb_en_ex_mem_o             (reg_wb_en_ex_mem),
        .rd_ex_mem_o                    (rd_ex_mem),
        .pc_ex_mem_o                    (pc_ex_mem),
        .wb_sel_ex_mem_o                (wb_sel_ex_mem),
        .imm_ex_mem_o                   (imm_ex_mem),
        .alu_out_ex_mem_o               (alu_ex_mem),
        .rs2_ex_mem_o                   (rs2_ex_mem),
        .funct3_ex_mem_o                (funct3),
        .is_load_instr_ex_mem_o         (is_load),
        .is_store_instr_ex_mem_o        (is_store),
        .dmem_req_o                     (dmem_req),
        .dmem_we_o                      (dmem_we),
        .dmem_addr_o                    (dmem_addr),
        .dmem_wdata_o                   (dmem_wdata),
        .dmem_wstrb_o                   (dmem_wstrb),
        .dmem_ready_i                   (dmem_ready),
        .dmem_rdata_i                   (dmem_rdata),
        .busywait_o                     (busywait),
        .reg_wb_en_mem_wb_o             (reg_wb_en_mem_wb),
        .rd_mem_wb_o                    (rd_mem_wb),
        .pc_mem_wb_o                    (pc_mem_wb),
        .wb_sel_mem_wb_o                (wb_sel_mem_wb),
        .imm_mem_wb_o                   (imm_mem_wb),
        .alu_out_mem_wb_o               (alu_mem_wb),
        .rd_data_mem_wb_o               (rd_data_mem_wb),
        .is_memory_instruction_mem_wb_o (is_mem_mem_wb),
        .mem_fault_mem_wb_o             (fault_mem_wb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        is_load          = v.ld;
        is_store         = v.st;
        funct3           = v.f3;
        alu_ex_mem       = v.addr;
        rs2_ex_mem       = v.rs2;
        reg_wb_en_ex_mem = v.wb_en;
        rd_ex_mem        = v.rd;
        pc_ex_mem        = v.pc;
        wb_sel_ex_mem    = v.wb_sel;
        imm_ex_mem       = v.imm;
        dmem_rdata       = v.rdata;
    endtask

    // Called at a falling edge; returns at the falling edge after the stage advances.
    task automatic issue(input int id, input vec_t v);
        wb_t e;
        int  reqc = 0;
        int  busyc = 0;
        int  k = 0;
        bit  done = 1'b0;
        drive(v);
        e = '{v.x_wb_en, v.rd, v.pc, v.wb_sel, v.imm, v.addr, v.x_rd_data, v.x_is_mem, v.x_fault};
        exp_q.push_back(e);
        while (!done && k < 40) begin
            dmem_ready = ((k == int'(v.waits)) && v.x_req) || ((k == 0) && v.stray);
            #1;
            if (dmem_req) begin
                reqc++;
                check($sformatf("v%0d.we", id), 32'(dmem_we), 32'(v.x_we));
                check($sformatf("v%0d.addr", id), dmem_addr, v.x_addr);
                check($sformatf("v%0d.wstrb", id), 32'(dmem_wstrb), 32'(v.x_wstrb));
                if (v.x_we) check($sformatf("v%0d.wdata", id), dmem_wdata, v.x_wdata);
            end
            if (busywait) busyc++;
            done = !busywait;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        dmem_ready = 1'b0;
        if (!done) check($sformatf("v%0d.advance_timeout", id), 32'd0, 32'd1);
        check($sformatf("v%0d.req_cycles", id), 32'(reqc), v.x_req ? 32'(v.waits) + 32'd1 : 32'd0);
        check($sformatf("v%0d.busy_cycles", id), 32'(busyc), v.x_req ? 32'(v.waits) : 32'd0);
    endtask

    always @(negedge clk) begin
        #1;
        adv = !busywait && !rst;
        bub = busywait && !rst;
    end

    always @(posedge clk) begin
        bit  a, b;
        wb_t e;
        if (!rst) begin
            a = adv;
            b = bub;
            #1;
            if (a) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_writeback", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("wb%0d.reg_wb_en", n_pop), 32'(reg_wb_en_mem_wb), 32'(e.wb_en));
                    check($sformatf("wb%0d.rd", n_pop), 32'(rd_mem_wb), 32'(e.rd));
                    check($sformatf("wb%0d.pc", n_pop), pc_mem_wb, e.pc);
                    check($sformatf("wb%0d.wb_sel", n_pop), 32'(wb_sel_mem_wb), 32'(e.wb_sel));
                    check($sformatf("wb%0d.imm", n_pop), imm_mem_wb, e.imm);
                    check($sformatf("wb%0d.alu_out", n_pop), alu_mem_wb, e.alu);
                    check($sformatf("wb%0d.rd_data", n_pop), rd_data_mem_wb, e.rd_data);
                    check($sformatf("wb%0d.is_mem", n_pop), 32'(is_mem_mem_wb), 32'(e.is_mem));
                    check($sformatf("wb%0d.fault", n_pop), 32'(fault_mem_wb), 32'(e.fault));
                    n_pop++;
                end
            end else if (b) begin
                check("bubble.reg_wb_en", 32'(reg_wb_en_mem_wb), 32'd0);
                check("bubble.is_mem", 32'(is_mem_mem_wb), 32'd0);
                check("bubble.fault", 32'(fault_mem_wb), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t sv;
        //         ld   st   f3      addr          rs2           wbe  rd     pc            sel   imm         rdata         wt    str
        //         req  we   x_addr        x_wstrb   x_wdata       x_wbe x_rd_data    x_mem x_flt
        vecs[0]  = '{1'b1,1'b0,3'b010,32'h104,32'h0,1'b1,5'd5,32'h100,2'd1,32'h4,32'hDEADBEEF,4'd3,1'b0,
                     1'b1,1'b0,32'h104,4'b0000,32'h0,1'b1,32'hDEADBEEF,1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b0,3'b000,32'h203,32'h0,1'b1,5'd6,32'h104,2'd1,32'h3,32'h80FF1234,4'd1,1'b0,
                     1'b1,1'b0,32'h200,4'b0000,32'h0,1'b1,32'hFFFFFF80,1'b1,1'b0};
        vecs[2]  = '{1'b1,1'b0,3'b100,32'h203,32'h0,1'b1,5'd7,32'h108,2'd1,32'h3,32'h80FF1234,4'd1,1'b0,
                     1'b1,1'b0,32'h200,4'b0000,32'h0,1'b1,32'h00000080,1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b0,3'b001,32'h202,32'h0,1'b1,5'd8,32'h10C,2'd1,32'h2,32'h80FF1234,4'd2,1'b0,
                     1'b1,1'b0,32'h200,4'b0000,32'h0,1'b1,32'hFFFF80FF,1'b1,1'b0};
        vecs[4]  = '{1'b1,1'b0,3'b101,32'h200,32'h0,1'b1,5'd9,32'h110,2'd1,32'h0,32'h80FF1234,4'd1,1'b1,
                     1'b1,1'b0,32'h200,4'b0000,32'h0,1'b1,32'h00001234,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b1,3'b001,32'h12,32'h0000ABCD,1'b1,5'd10,32'h114,2'd0,32'h12,32'h0,4'd2,1'b0,
                     1'b1,1'b1,32'h10,4'b1100,32'hABCDABCD,1'b0,32'h0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,3'b000,32'h21,32'h12345678,1'b1,5'd11,32'h118,2'd0,32'h21,32'h0,4'd1,1'b0,
                     1'b1,1'b1,32'h20,4'b0010,32'h78787878,1'b0,32'h0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,3'b010,32'h30,32'hCAFEF00D,1'b1,5'd12,32'h11C,2'd0,32'h30,32'h0,4'd1,1'b0,
                     1'b1,1'b1,32'h30,4'b1111,32'hCAFEF00D,1'b0,32'h0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,3'b010,32'h102,32'h0,1'b1,5'd13,32'h120,2'd1,32'h2,32'hDEADBEEF,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,32'h0,1'b0,1'b1};
        vecs[9]  = '{1'b0,1'b0,3'b000,32'h55,32'h0,1'b1,5'd14,32'h124,2'd0,32'h0,32'h0,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b1,32'h0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,3'b010,32'h40,32'h0,1'b1,5'd15,32'h128,2'd1,32'h0,32'h0,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,32'h0,1'b0,1'b1};
        vecs[11] = '{1'b1,1'b0,3'b011,32'h40,32'h0,1'b1,5'd16,32'h12C,2'd1,32'h0,32'h0,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,32'h0,1'b0,1'b1};
        vecs[12] = '{1'b0,1'b1,3'b010,32'h42,32'h1111,1'b1,5'd17,32'h130,2'd0,32'h0,32'h0,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,32'h0,1'b0,1'b1};
        vecs[13] = '{1'b1,1'b0,3'b001,32'h201,32'h0,1'b1,5'd18,32'h134,2'd1,32'h0,32'h0,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,32'h0,1'b0,1'b1};
        vecs[14] = '{1'b0,1'b1,3'b011,32'h40,32'h2222,1'b1,5'd19,32'h138,2'd0,32'h0,32'h0,4'd0,1'b0,
                     1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,32'h0,1'b0,1'b1};

        // A valid load is presented during reset; the request must stay gated off.
        rst = 1'b1;
        dmem_ready = 1'b0;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        #1;
        check("reset.req", 32'(dmem_req), 32'd0);
        check("reset.busywait", 32'(busywait), 32'd0);
        check("reset.we", 32'(dmem_we), 32'd0);
        check("reset.wstrb", 32'(dmem_wstrb), 32'd0);
        check("reset.reg_wb_en", 32'(reg_wb_en_mem_wb), 32'd0);
        check("reset.fault", 32'(fault_mem_wb), 32'd0);
        check("reset.pc", pc_mem_wb, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) issue(i, vecs[i]);

        // Reset in the middle of a WAIT: request must drop before any clock edge.
        drive(vecs[0]);
        dmem_ready = 1'b0;
        #1;
        check("midrst.req_idle", 32'(dmem_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midrst.req_wait", 32'(dmem_req), 32'd1);
        check("midrst.busy_wait", 32'(busywait), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.req", 32'(dmem_req), 32'd0);
        check("midrst.busywait", 32'(busywait), 32'd0);
        check("midrst.we", 32'(dmem_we), 32'd0);
        check("midrst.pc", pc_mem_wb, 32'd0);
        check("midrst.alu_out", alu_mem_wb, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Stray ready in the first cycle after release must not complete the access.
        sv = vecs[0];
        sv.waits = 4'd1;
        sv.stray = 1'b1;
        issue(15, sv);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
